// File: rtl/cs_window_param.sv
// cs_window_param: parametrised sliding-window filter.
// Keeps the last DEPTH accepted samples, derives the window sum, the
// integer average and the largest sample not above that average (Xappr).
// It then registers Y = (sum + DEPTH*Xappr) >> DIV_SHIFT.
// Optional feature macro: CS_WINDOW_ROUND_EN. When it is defined, the final
// shift rounds half up instead of truncating.
//
// state | meaning
// ------+----------------------------------------------------------
// FILL  | fewer than DEPTH samples accepted since reset; out_valid = 0
// RUN   | window holds DEPTH real samples; out_valid = 1 until reset
module cs_window_param #(
    parameter int DW        = 8,
    parameter int DEPTH     = 9,
    parameter int DIV_SHIFT = 3,
    parameter int OW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] X,
    output logic [OW-1:0] Y,
    output logic          out_valid
);

    localparam int SW = DW + $clog2(DEPTH);
    // One bit of headroom beyond sum + DEPTH*Xappr keeps the rounding term safe.
    localparam int IW = DW + $clog2(2 * DEPTH) + 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [DW-1:0] win     [DEPTH];
    logic [DW-1:0] win_nxt [DEPTH];
    logic [SW-1:0] sum, sum_nxt, avg;
    logic [DW-1:0] xappr;
    logic [IW-1:0] inter;
    logic [OW-1:0] y_nxt;

`ifdef CS_WINDOW_ROUND_EN
    localparam logic [IW-1:0] RND = (DIV_SHIFT > 0) ? (IW'(1) << (DIV_SHIFT - 1)) : '0;
`endif

    // Window after the candidate accept, plus the arithmetic that produces Y from it.
    always_comb begin
        win_nxt[0] = X;
        for (int i = 1; i < DEPTH; i++) begin
            win_nxt[i] = win[i-1];
        end
        sum_nxt = sum + SW'(X) - SW'(win[DEPTH-1]);
        avg     = sum_nxt / SW'(DEPTH);
        // Start from 0: the window minimum is always <= avg, so a zero start never wins wrongly.
        xappr   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((SW'(win_nxt[i]) <= avg) && (win_nxt[i] > xappr)) begin
                xappr = win_nxt[i];
            end
        end
        inter = IW'(sum_nxt) + IW'(DEPTH) * IW'(xappr);
`ifdef CS_WINDOW_ROUND_EN
        inter = inter + RND;
`endif
        y_nxt = OW'(inter >> DIV_SHIFT);
    end

    // Window, running sum and output register; all hold while in_valid is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                win[i] <= '0;
            end
            sum <= '0;
            Y   <= '0;
        end else if (in_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                win[i] <= win_nxt[i];
            end
            sum <= sum_nxt;
            Y   <= y_nxt;
        end
    end

    // Fill state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Fill next-state: count accepts until DEPTH, then stay in RUN until reset.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (in_valid && (state == FILL)) begin
            count_nxt = count + CW'(1);
            if (count_nxt == CW'(DEPTH)) begin
                state_nxt = RUN;
            end
        end
    end

    assign out_valid = (state == RUN);

endmodule

// File: tb/tb_cs_window_param.sv
// Randomised bench for cs_window_param with a queue-based reference model.
module tb_cs_window_param;

    localparam int DW        = 8;
    localparam int DEPTH     = 9;
    localparam int DIV_SHIFT = 3;
    localparam int OW        = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] X;
    logic [OW-1:0] Y;
    logic          out_valid;

    int n_chk  = 0;
    int n_fail = 0;

    int win_q[$];
    int fill;

    cs_window_param #(.DW(DW), .DEPTH(DEPTH), .DIV_SHIFT(DIV_SHIFT), .OW(OW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .X(X), .Y(Y), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        win_q.delete();
        for (int i = 0; i < DEPTH; i++) win_q.push_back(0);
        fill = 0;
    endfunction

    // Y from the window contents, straight from the filter definition.
    function automatic longint model_y();
        longint s = 0;
        longint a;
        longint xa = 0;
        foreach (win_q[i]) s += win_q[i];
        a = s / DEPTH;
        foreach (win_q[i]) if (win_q[i] <= a && win_q[i] > xa) xa = win_q[i];
        s = s + DEPTH * xa;
`ifdef CS_WINDOW_ROUND_EN
        if (DIV_SHIFT > 0) s = s + (longint'(1) << (DIV_SHIFT - 1));
`endif
        return s >> DIV_SHIFT;
    endfunction

    task automatic step(input bit v, input int x, input string tag);
        in_valid = v;
        X        = DW'(x);
        @(posedge clk);
        #1;
        if (v) begin
            win_q.push_front(x);
            void'(win_q.pop_back());
            if (fill < DEPTH) fill++;
        end
        check({tag, "_y"}, Y, model_y());
        check({tag, "_v"}, out_valid, (fill == DEPTH) ? 1 : 0);
    endtask

    initial begin
        longint y_hold;
        bit     v_hold;
        reset    = 1'b0;
        in_valid = 1'b0;
        X        = '0;
        model_clear();
        #12;
        check("rst_y", Y, 0);
        check("rst_v", out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Ramp 1..9: out_valid rises only on the ninth accept.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, i, "ramp");
            if (i == DEPTH - 1) check("ramp8_v", out_valid, 0);
        end
        check("ramp9_v", out_valid, 1);
        check("ramp9_y", Y, 11);

        step(1'b1, 10, "x10");
`ifdef CS_WINDOW_ROUND_EN
        check("x10_const", Y, 14);
`else
        check("x10_const", Y, 13);
`endif

        for (int i = 0; i < 8; i++) step(1'b1, 0, "zeros");
        step(1'b1, 100, "x100");
`ifdef CS_WINDOW_ROUND_EN
        check("x100_const", Y, 13);
`else
        check("x100_const", Y, 12);
`endif

        for (int i = 0; i < DEPTH; i++) step(1'b1, 255, "max");
`ifdef CS_WINDOW_ROUND_EN
        check("max_const", Y, 574);
`else
        check("max_const", Y, 573);
`endif

        // Stall: random X with in_valid low must not disturb anything.
        step(1'b1, 37, "pre_stall");
        y_hold = Y;
        v_hold = out_valid;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, $urandom_range(0, 255), "stall");
            check("stall_hold_y", Y, y_hold);
            check("stall_hold_v", out_valid, v_hold);
        end
        step(1'b1, 200, "post_stall");

        // Asynchronous reset between edges while in RUN.
        #3;
        reset = 1'b0;
        #1;
        model_clear();
        check("async_rst_y", Y, 0);
        check("async_rst_v", out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, $urandom_range(0, 255), "refill");
            if (i < DEPTH - 1) check("refill_lo_v", out_valid, 0);
        end
        check("refill_done_v", out_valid, 1);

        // Random stream with random stalls and occasional extremes.
        for (int i = 0; i < 400; i++) begin
            int x;
            case ($urandom_range(0, 7))
                0:       x = 0;
                1:       x = 255;
                default: x = $urandom_range(0, 255);
            endcase
            step($urandom_range(0, 3) != 0, x, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cs_window_param.md
Name: cs_window_param

Overview:
- Parametrised successor to the fixed 8-bit / 9-sample CS sliding-window filter.
- Keeps a sliding window of the last DEPTH accepted samples and computes three values:
  - sum of the window;
  - integer average = floor(sum/DEPTH);
  - approximate value Xappr = the largest window sample that is ≤ the average.
- Outputs Y = (sum + DEPTH*Xappr) >> DIV_SHIFT.
- Adds an input valid qualifier (stall support) and an output valid flag. Sits in the same datapath slot as CS, between the sample source and the downstream consumer.

Parameters:
- DW, 8, sample width in bits.
- DEPTH, 9, window length in samples; must be at least 2.
- DIV_SHIFT, 3, final right-shift amount.
- OW, 10, output width; must satisfy (2*DEPTH*(2^DW-1)) >> DIV_SHIFT ≤ 2^OW-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset; 0 = reset asserted.
- in_valid  input  1  X is accepted on a clk rising edge when this is 1.
- X  input  DW  sample, unsigned.
- Y  output  OW  filter result, unsigned, registered.
- out_valid  output  1  1 when Y reflects a full window.

Behaviour:
- Reset (reset=0, asynchronous):
  - all window entries = 0;
  - fill count = 0;
  - running sum = 0;
  - Y = 0, out_valid = 0.
  - Reset taking effect mid-operation discards all history. DEPTH new accepted samples are needed before out_valid returns to 1.
- Accept (rising edge, reset=1, in_valid=1):
  - X is shifted into the window and the oldest sample is dropped.
  - Running sum is updated: sum_next = sum + X - oldest, held in DW+ceil(log2(DEPTH)) bits with no overflow.
  - Y is updated on the same edge from the new window, including X. Latency from X to Y is 1 cycle.
- Stall (in_valid=0): window, sum, Y and out_valid all hold their values.
- Fill state machine:
  - FILL (count < DEPTH): each accept increments count. Y still updates every accept, computed over the partial window with zero-filled entries; out_valid = 0.
  - RUN is entered on the edge that accepts the DEPTH-th sample; out_valid goes to 1 on that edge.
  - RUN is left only by reset. The count saturates at DEPTH.
- Arithmetic:
  - avg = floor(sum/DEPTH), computed combinationally as a constant divide.
  - Xappr = max over window of entries with entry ≤ avg. The window minimum always qualifies, so a result always exists.
  - If several entries are equal, their value is used; which entry supplied it is irrelevant.
  - All operations are unsigned. The intermediate sum + DEPTH*Xappr is at least DW+ceil(log2(2*DEPTH)) bits wide.
  - Y = intermediate >> DIV_SHIFT (floor), truncated to OW bits. The parameter rule guarantees no truncation loss.
- Timing: X may change at any time outside the setup/hold window of the clk rising edge. Y changes only just after a rising edge.

Optional Feature:
- Macro: CS_WINDOW_ROUND_EN.
- Defined: Y = (intermediate + 2^(DIV_SHIFT-1)) >> DIV_SHIFT, i.e. round half up. If DIV_SHIFT = 0, no rounding term is added. The OW check adds 1 to the bound.
- Undefined: Y uses floor as specified above.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset, then accept X=1..9 on consecutive cycles:
  - out_valid rises on the 9th accept edge;
  - Y=11 (sum 45, avg 5, Xappr 5, 90>>3).
- Continue with X=10:
  - window is 2..10, Y=13 floor;
  - Y=14 with CS_WINDOW_ROUND_EN (108/8=13.5).
- Accept 8×0 then 100:
  - sum 100, avg 11, Xappr 0;
  - Y=12 floor, or 13 rounded.
- Accept 9×255 (maximum value):
  - Y=573 floor, or 574 rounded;
  - no overflow in Y or the internal sum.
- Hold in_valid=0 for 5 cycles mid-stream while X toggles randomly: Y and out_valid stay unchanged. The next accept continues the window correctly.
- Pull reset low asynchronously between edges while in RUN:
  - Y=0 and out_valid=0 immediately, without waiting for a clock edge;
  - after release, out_valid stays 0 until 9 further accepts.
